// File: rtl/systolic_output_deskew_if.sv
// Row bus of the output deskew block: skewed column input, aligned row output and FIFO status.
interface systolic_output_deskew_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N_COL = 4,
    parameter int unsigned DEPTH = 8
) ();
    localparam int unsigned AW = $clog2(DEPTH);

    logic                   IN_VALID;
    logic [N_COL*WIDTH-1:0] IN_DATA;
    logic                   OUT_VALID;
    logic                   OUT_READY;
    logic [N_COL*WIDTH-1:0] OUT_DATA;
    logic                   ALMOST_FULL;
    logic [AW:0]            LEVEL;
    logic                   OVERFLOW;

    // Environment side: drives the skewed columns and the downstream ready
    modport master (
        output IN_VALID, IN_DATA, OUT_READY,
        input  OUT_VALID, OUT_DATA, ALMOST_FULL, LEVEL, OVERFLOW
    );

    // Deskew block side
    modport slave (
        input  IN_VALID, IN_DATA, OUT_READY,
        output OUT_VALID, OUT_DATA, ALMOST_FULL, LEVEL, OVERFLOW
    );
endinterface

// File: rtl/systolic_output_deskew.sv
// Realigns staircase column results of the systolic array and queues whole rows
// for a valid/ready consumer.
module systolic_output_deskew #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N_COL = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    systolic_output_deskew_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned RW = N_COL * WIDTH;
    localparam int unsigned PD = N_COL - 1;

    logic          push_c;        // aligned row present this cycle
    logic [RW-1:0] row_c;         // aligned row
    logic [31:0]   inflight_nxt;  // rows in the valid pipeline after this edge

    // Valid pipeline: a row is complete once its IN_VALID reaches the end
    if (PD == 0) begin : g_nopipe
        assign push_c       = bus.IN_VALID;
        assign inflight_nxt = 32'd0;
    end else begin : g_pipe
        logic [PD-1:0] vld_q;

        // Shift IN_VALID towards the write point
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) vld_q <= '0;
            else     vld_q <= PD'({vld_q, bus.IN_VALID});
        end

        assign push_c       = vld_q[PD-1];
        // Entering row counted, row leaving to the FIFO not counted
        assign inflight_nxt = 32'($countones(vld_q)) + 32'(bus.IN_VALID) - 32'(vld_q[PD-1]);
    end

    // Per-column delay lines: column c waits N_COL-1-c cycles for the last column
    for (genvar c = 0; c < N_COL; c++) begin : g_col
        localparam int unsigned D   = N_COL - 1 - c;
        localparam int unsigned SRW = (D == 0) ? 1 : D * WIDTH;

        if (D == 0) begin : g_direct
            assign row_c[c*WIDTH +: WIDTH] = bus.IN_DATA[c*WIDTH +: WIDTH];
        end else begin : g_dly
            logic [SRW-1:0] sr_q;

            // Shift column data; oldest sample sits in the top slice
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) sr_q <= '0;
                else     sr_q <= SRW'({sr_q, bus.IN_DATA[c*WIDTH +: WIDTH]});
            end

            assign row_c[c*WIDTH +: WIDTH] = sr_q[(D-1)*WIDTH +: WIDTH];
        end
    end

    logic [RW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_q, rd_q, level_q;
    logic [PW-1:0] wr_nxt, rd_nxt, level_nxt;
    logic          out_valid_q, af_q, ovf_q;
    logic [RW-1:0] out_data_q;
    logic          out_valid_nxt, af_nxt, ovf_nxt;
    logic [RW-1:0] out_data_nxt;
    logic          pop_c, full_c, push_ok_c;

    // FIFO next state: pop frees a slot before the push is judged
    always_comb begin
        pop_c         = out_valid_q && bus.OUT_READY;
        full_c        = (wr_q ^ rd_q) == PW'(DEPTH);
        push_ok_c     = push_c && (!full_c || pop_c);
        wr_nxt        = wr_q + PW'(push_ok_c);
        rd_nxt        = rd_q + PW'(pop_c);
        level_nxt     = level_q + PW'(push_ok_c) - PW'(pop_c);
        ovf_nxt       = ovf_q || (push_c && full_c && !pop_c);
        out_valid_nxt = wr_nxt != rd_nxt;
        out_data_nxt  = out_data_q;
        if (out_valid_nxt) begin
            // New head is the row being written now when everything older is gone
            if (push_ok_c && (rd_nxt == wr_q)) out_data_nxt = row_c;
            else                               out_data_nxt = mem[rd_nxt[AW-1:0]];
        end
        af_nxt        = (32'(level_nxt) + inflight_nxt) >= 32'(DEPTH - 1);
    end

    // Row storage, no reset needed: contents only observed behind the pointers
    always_ff @(posedge CLK) begin
        if (push_ok_c) mem[wr_q[AW-1:0]] <= row_c;
    end

    // Pointers, level, status and registered head row
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_q        <= '0;
            rd_q        <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            af_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            wr_q        <= wr_nxt;
            rd_q        <= rd_nxt;
            level_q     <= level_nxt;
            out_valid_q <= out_valid_nxt;
            out_data_q  <= out_data_nxt;
            af_q        <= af_nxt;
            ovf_q       <= ovf_nxt;
        end
    end

    assign bus.OUT_VALID   = out_valid_q;
    assign bus.OUT_DATA    = out_data_q;
    assign bus.ALMOST_FULL = af_q;
    assign bus.LEVEL       = level_q;
    assign bus.OVERFLOW    = ovf_q;
endmodule

// File: tb/tb_systolic_output_deskew.sv
// Directed bench for the systolic output deskew block (WIDTH=16, N_COL=4, DEPTH=8).
module tb_systolic_output_deskew;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned N_COL = 4;
    localparam int unsigned DEPTH = 8;

    logic CLK;
    logic RST;

    systolic_output_deskew_if #(.WIDTH(WIDTH), .N_COL(N_COL), .DEPTH(DEPTH)) bus ();

    systolic_output_deskew #(.WIDTH(WIDTH), .N_COL(N_COL), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        rdy;
        logic        eov;
        logic        chkd;
        logic [63:0] eod;
        logic [3:0]  elvl;
    } vec_t;

    vec_t tbl [6];

    // Reference state: issue history (index c = issued c edges ago), level, head queue
    logic        hv [N_COL];
    logic [63:0] hr [N_COL];
    int          lvl_m;
    logic        ovf_m;
    logic        af_m;
    logic [63:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [63:0] mkrow(input int i);
        logic [63:0] r;
        for (int c = 0; c < N_COL; c++) r[c*16 +: 16] = 16'(16'h1000 * (c + 1) + i);
        return r;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < N_COL; c++) begin
            hv[c] = 1'b0;
            hr[c] = '0;
        end
        lvl_m = 0;
        ovf_m = 1'b0;
        af_m  = 1'b0;
        exp_q.delete();
    endtask

    // One clock: drive the staircase for all rows in flight, then check against the model
    task automatic cycle(input logic v, input logic [63:0] row, input logic rdy);
        logic        push, pop, full;
        int          infl;
        logic [63:0] d;
        for (int c = N_COL - 1; c > 0; c--) begin
            hv[c] = hv[c-1];
            hr[c] = hr[c-1];
        end
        hv[0] = v;
        hr[0] = row;
        for (int c = 0; c < N_COL; c++)
            d[c*16 +: 16] = hv[c] ? hr[c][c*16 +: 16] : 16'(16'hBAD0 + c);
        bus.IN_VALID  = v;
        bus.IN_DATA   = d;
        bus.OUT_READY = rdy;
        step();
        push = hv[N_COL-1];
        pop  = (lvl_m > 0) && rdy;
        full = (lvl_m == DEPTH);
        if (pop) void'(exp_q.pop_front());
        if (push && (!full || pop)) exp_q.push_back(hr[N_COL-1]);
        else if (push) ovf_m = 1'b1;
        lvl_m = exp_q.size();
        infl = 0;
        for (int c = 0; c < N_COL - 1; c++) infl += int'(hv[c]);
        af_m = (lvl_m + infl) >= (DEPTH - 1);
        chk("level", 64'(bus.LEVEL), 64'(lvl_m));
        chk("out_valid", 64'(bus.OUT_VALID), 64'(lvl_m > 0));
        chk("overflow", 64'(bus.OVERFLOW), 64'(ovf_m));
        chk("almost_full", 64'(bus.ALMOST_FULL), 64'(af_m));
        if (lvl_m > 0) chk("head_row", bus.OUT_DATA, exp_q[0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued;
        int guard;

        // Single row, other columns carry junk that must never reach the output
        tbl[0] = '{1'b1, 64'hFFFF_FFFF_FFFF_0010, 1'b1, 1'b0, 1'b0, 64'h0, 4'd0};
        tbl[1] = '{1'b0, 64'hFFFF_FFFF_0011_FFFF, 1'b1, 1'b0, 1'b0, 64'h0, 4'd0};
        tbl[2] = '{1'b0, 64'hFFFF_0012_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'h0, 4'd0};
        tbl[3] = '{1'b0, 64'h0013_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 64'h0013_0012_0011_0010, 4'd1};
        tbl[4] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'h0, 4'd0};
        tbl[5] = '{1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 64'h0, 4'd0};

        RST           = 1'b1;
        bus.IN_VALID  = 1'b0;
        bus.IN_DATA   = '0;
        bus.OUT_READY = 1'b0;
        model_clear();
        #12;
        chk("rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("rst_out_data", bus.OUT_DATA, 64'd0);
        chk("rst_almost_full", 64'(bus.ALMOST_FULL), 64'd0);
        chk("rst_level", 64'(bus.LEVEL), 64'd0);
        chk("rst_overflow", 64'(bus.OVERFLOW), 64'd0);
        RST = 1'b0;
        step();

        // Test 1: single row through the table
        for (int i = 0; i < 6; i++) begin
            bus.IN_VALID  = tbl[i].v;
            bus.IN_DATA   = tbl[i].d;
            bus.OUT_READY = tbl[i].rdy;
            step();
            chk($sformatf("t1_valid[%0d]", i), 64'(bus.OUT_VALID), 64'(tbl[i].eov));
            chk($sformatf("t1_level[%0d]", i), 64'(bus.LEVEL), 64'(tbl[i].elvl));
            if (tbl[i].chkd) chk($sformatf("t1_data[%0d]", i), bus.OUT_DATA, tbl[i].eod);
        end

        // Test 2: 20 back-to-back rows, always ready
        for (int i = 0; i < 20; i++) cycle(1'b1, mkrow(i), 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

        // Test 3: backpressure fills the FIFO, then drain
        for (int i = 0; i < 8; i++) cycle(1'b1, mkrow(100 + i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
        chk("t3_level_full", 64'(bus.LEVEL), 64'd8);
        chk("t3_almost_full", 64'(bus.ALMOST_FULL), 64'd1);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);

        // Test 4: full FIFO, push and pop on the same edge, then a dropped push
        for (int i = 0; i < 8; i++) cycle(1'b1, mkrow(200 + i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
        cycle(1'b1, mkrow(300), 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        chk("t4_level_swap", 64'(bus.LEVEL), 64'd8);
        chk("t4_no_overflow", 64'(bus.OVERFLOW), 64'd0);
        cycle(1'b1, mkrow(301), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
        chk("t4_overflow", 64'(bus.OVERFLOW), 64'd1);
        chk("t4_level_drop", 64'(bus.LEVEL), 64'd8);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1);

        // Test 5: asynchronous reset two cycles into a row with LEVEL=3
        for (int i = 0; i < 3; i++) cycle(1'b1, mkrow(400 + i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
        cycle(1'b1, mkrow(403), 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("t5_level_pre", 64'(bus.LEVEL), 64'd3);
        #2;
        RST = 1'b1;
        #1;
        chk("t5_out_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("t5_out_data", bus.OUT_DATA, 64'd0);
        chk("t5_almost_full", 64'(bus.ALMOST_FULL), 64'd0);
        chk("t5_level", 64'(bus.LEVEL), 64'd0);
        chk("t5_overflow", 64'(bus.OVERFLOW), 64'd0);
        bus.IN_VALID = 1'b0;
        @(posedge CLK);
        #2;
        RST = 1'b0;
        model_clear();
        cycle(1'b1, mkrow(500), 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

        // Test 6: 40 rows, random ready, upstream honours ALMOST_FULL
        issued = 0;
        guard  = 0;
        while (issued < 40 && guard < 2000) begin
            if (!af_m && ($urandom_range(0, 3) != 0)) begin
                cycle(1'b1, mkrow(600 + issued), 1'($urandom_range(0, 1)));
                issued++;
            end else begin
                cycle(1'b0, '0, 1'($urandom_range(0, 1)));
            end
            guard++;
        end
        chk("t6_rows_issued", 64'(issued), 64'd40);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
        chk("t6_drained", 64'(bus.LEVEL), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
